// File: rtl/clock_pkg.sv
// Shared types and widths for the digital clock timekeeping slice.
package clock_pkg;

    localparam int STATE_W = 3;
    localparam int FIELD_W = 6;

    typedef logic [FIELD_W-1:0] field_t;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN         = 3'd0,
        ST_SET_HOUR    = 3'd1,
        ST_SET_MIN     = 3'd2,
        ST_SET_AL_HOUR = 3'd3,
        ST_SET_AL_MIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mod_counter.sv
// Wrapping counter 0..max with synchronous clear; carry flags the wrap increment.
module mod_counter
    import clock_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  field_t max,
    output field_t val,
    output logic   carry
);

    assign carry = en && (val == max);

    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
        end else if (en) begin
            val <= (val == max) ? '0 : val + field_t'(1);
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: cascaded sec/min/hour counters plus time-set FSM.
// Optional alarm registers and comparator are compiled in with `define ALARM_EN.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               btn_mode,
    input  logic               btn_inc,
    output logic [FIELD_W-1:0] sec,
    output logic [FIELD_W-1:0] min,
    output logic [FIELD_W-1:0] hour,
    output logic [STATE_W-1:0] mode,
    output logic               alarm_hit
);

    state_t state;
    logic   sec_en, min_en, hour_en;
    logic   sec_carry, min_carry, hour_carry;
    logic   sec_clr;
    logic   inc_only;

    assign inc_only = btn_inc && !btn_mode;
    // Leaving SET_MIN restarts the minute from :00.
    assign sec_clr  = (state == ST_SET_MIN) && btn_mode;
    assign mode     = state;

    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hour_en = 1'b0;
        case (state)
            ST_RUN: begin
                sec_en  = tick_1hz;
                min_en  = sec_carry;
                hour_en = min_carry;
            end
            ST_SET_HOUR: hour_en = inc_only;
            ST_SET_MIN:  min_en  = inc_only;
            default: ;
        endcase
    end

    mod_counter u_sec (
        .clk   (clk),
        .rst   (rst || sec_clr),
        .en    (sec_en),
        .max   (field_t'(SEC_MAX)),
        .val   (sec),
        .carry (sec_carry)
    );

    mod_counter u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en),
        .max   (field_t'(MIN_MAX)),
        .val   (min),
        .carry (min_carry)
    );

    mod_counter u_hour (
        .clk   (clk),
        .rst   (rst),
        .en    (hour_en),
        .max   (field_t'(HOUR_MAX)),
        .val   (hour),
        .carry (hour_carry)
    );

`ifdef ALARM_EN
    field_t al_hour, al_min;
    logic   al_hour_carry, al_min_carry;
    logic   armed;
    field_t nxt_min, nxt_hour;
    logic   alarm_match;

    mod_counter u_al_hour (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == ST_SET_AL_HOUR) && inc_only),
        .max   (field_t'(HOUR_MAX)),
        .val   (al_hour),
        .carry (al_hour_carry)
    );

    mod_counter u_al_min (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == ST_SET_AL_MIN) && inc_only),
        .max   (field_t'(MIN_MAX)),
        .val   (al_min),
        .carry (al_min_carry)
    );

    // Compare against the post-tick time so the pulse lands right after the :00 tick.
    always_comb begin
        nxt_min     = min_carry  ? '0 : min + field_t'(1);
        nxt_hour    = hour_carry ? '0 : (min_carry ? hour + field_t'(1) : hour);
        alarm_match = armed && (state == ST_RUN) && !btn_mode && sec_carry
                      && (nxt_min == al_min) && (nxt_hour == al_hour);
    end
`else
    assign alarm_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
`ifdef ALARM_EN
            armed     <= 1'b0;
            alarm_hit <= 1'b0;
`endif
        end else begin
`ifdef ALARM_EN
            alarm_hit <= alarm_match;
`endif
            if (btn_mode) begin
                case (state)
                    ST_RUN:      state <= ST_SET_HOUR;
                    ST_SET_HOUR: state <= ST_SET_MIN;
`ifdef ALARM_EN
                    ST_SET_MIN:     state <= ST_SET_AL_HOUR;
                    ST_SET_AL_HOUR: state <= ST_SET_AL_MIN;
                    ST_SET_AL_MIN: begin
                        state <= ST_RUN;
                        armed <= 1'b1;
                    end
`else
                    ST_SET_MIN:  state <= ST_RUN;
`endif
                    default:     state <= ST_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl (both ALARM_EN builds).
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, btn_mode, btn_inc;
    logic [5:0] sec, min, hour;
    logic [2:0] mode;
    logic       alarm_hit;

    int tests  = 0;
    int failed = 0;
    int hits   = 0;

`ifdef ALARM_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    clock_time_ctrl #(.SEC_MAX(59), .MIN_MAX(59), .HOUR_MAX(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .mode      (mode),
        .alarm_hit (alarm_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, int'(hour), h);
        check({tag, ".min"},  int'(min),  m);
        check({tag, ".sec"},  int'(sec),  s);
    endtask

    // One clock: drive pulses, clock them in, sample 1ns after the edge.
    task automatic step(input bit t, input bit m, input bit i);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        if (alarm_hit) hits++;
    endtask

    task automatic steps(input int n, input bit t, input bit m, input bit i);
        for (int k = 0; k < n; k++) step(t, m, i);
    endtask

    task automatic exit_from_set_min;
        steps(AL ? 3 : 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_time(input int h_incs, input int m_incs);
        step(0, 1, 0);
        steps(h_incs, 0, 0, 1);
        step(0, 1, 0);
        steps(m_incs, 0, 0, 1);
        exit_from_set_min();
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        steps(2, 0, 0, 0);
        rst = 1'b0;
        check_time("por", 0, 0, 0);
        check("por.mode", int'(mode), 0);
        check("por.alarm", int'(alarm_hit), 0);

        // Reach 12:34:56 then reset in the middle of SET_MIN.
        set_time(12, 34);
        steps(56, 1, 0, 0);
        steps(2, 0, 1, 0);
        check_time("pre_rst", 12, 34, 56);
        check("pre_rst.mode", int'(mode), 2);
        rst = 1'b1;
        step(1, 0, 1);
        rst = 1'b0;
        check_time("mid_rst", 0, 0, 0);
        check("mid_rst.mode", int'(mode), 0);
        check("mid_rst.alarm", int'(alarm_hit), 0);

        // Full cascade wrap; with ALARM_EN the alarm is armed at 00:00 here.
        set_time(23, 59);
        check("run.mode", int'(mode), 0);
        steps(58, 1, 0, 0);
        check_time("t58", 23, 59, 58);
        step(1, 0, 0);
        check_time("t59", 23, 59, 59);
        step(1, 0, 0);
        check_time("wrap", 0, 0, 0);
        check("wrap.alarm", int'(alarm_hit), AL ? 1 : 0);
        steps(5, 1, 0, 0);
        check("wrap.alarm_off", int'(alarm_hit), 0);
        check_time("t5", 0, 0, 5);

        // Tick and btn_mode together in RUN: tick lands, state advances.
        step(1, 1, 0);
        check_time("mode_tick", 0, 0, 6);
        check("mode_tick.mode", int'(mode), 1);
        steps(25, 0, 0, 1);
        check("hour_wrap", int'(hour), 1);
        step(1, 0, 0);
        check_time("frozen_h", 1, 0, 6);
        step(0, 1, 0);
        check("set_min.mode", int'(mode), 2);
        steps(3, 0, 0, 1);
        step(1, 0, 0);
        check_time("frozen_m", 1, 3, 6);
        exit_from_set_min();
        check_time("exit_set", 1, 3, 0);
        check("exit_set.mode", int'(mode), 0);

        // btn_mode wins over btn_inc in SET_HOUR.
        step(0, 1, 0);
        step(0, 1, 1);
        check("mode_inc.mode", int'(mode), 2);
        check_time("mode_inc", 1, 3, 0);
        exit_from_set_min();
        steps(60, 1, 0, 0);
        check_time("min_carry", 1, 4, 0);

`ifdef ALARM_EN
        check("hits_before", hits, 1);
        step(0, 1, 0);
        steps(23, 0, 0, 1);
        step(0, 1, 0);
        steps(57, 0, 0, 1);
        check("min_set_wrap", int'(min), 1);
        step(0, 1, 0);
        check("al_hour.mode", int'(mode), 3);
        step(0, 1, 0);
        check("al_min.mode", int'(mode), 4);
        steps(2, 0, 0, 1);
        check_time("al_frozen", 0, 1, 0);
        step(0, 1, 0);
        check("armed.mode", int'(mode), 0);
        steps(59, 1, 0, 0);
        check_time("pre_al", 0, 1, 59);
        check("pre_al.alarm", int'(alarm_hit), 0);
        step(1, 0, 0);
        check_time("al_time", 0, 2, 0);
        check("al_pulse", int'(alarm_hit), 1);
        step(0, 0, 0);
        check("al_pulse_end", int'(alarm_hit), 0);
        step(0, 1, 0);
        steps(3, 1, 0, 0);
        check("al_set_quiet", int'(alarm_hit), 0);
        check_time("al_set_frozen", 0, 2, 0);
`endif
        check("alarm_count", hits, AL ? 2 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping controller for the board's digital clock. Sequences the cascaded seconds/minutes/hours mod counters from a 1 Hz tick, runs the user time-set state machine driven by two debounced buttons, and optionally compares against an alarm time. Sits between the tick divider/button debouncers and the 7-segment display driver.

## Interface
Parameters:
- SEC_MAX, 59, last seconds value before wrap
- MIN_MAX, 59, last minutes value before wrap
- HOUR_MAX, 23, last hours value before wrap

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick_1hz  in  1  one-cycle pulse per second from the divider
- btn_mode  in  1  one-cycle pulse, debounced; advances set-mode state
- btn_inc  in  1  one-cycle pulse, debounced; increments the field being edited
- sec  out  6  seconds, 0..SEC_MAX
- min  out  6  minutes, 0..MIN_MAX
- hour  out  6  hours, 0..HOUR_MAX
- mode  out  3  current FSM state encoding, for display blinking
- alarm_hit  out  1  one-cycle alarm pulse (driven 0 when ALARM_EN is absent)

## Operation
- Reset (rst=1 at a clk edge): sec=min=hour=0, mode=RUN, alarm_hit=0, alarm registers 00:00, alarm disarmed. Reset overrides every other input in that cycle, including mid-edit.
- States and encoding: RUN=0, SET_HOUR=1, SET_MIN=2, SET_AL_HOUR=3, SET_AL_MIN=4 (3 and 4 exist only with ALARM_EN).
- Transitions on btn_mode: RUN→SET_HOUR→SET_MIN→RUN. With ALARM_EN: SET_MIN→SET_AL_HOUR→SET_AL_MIN→RUN. No other transition sources.
- RUN: on tick_1hz, sec increments. At sec=SEC_MAX it wraps to 0 and carries into min. At min=MIN_MAX with a carry, min wraps to 0 and carries into hour. At hour=HOUR_MAX with a carry, hour wraps to 0. The full cascade resolves in one cycle. btn_inc is ignored.
- SET_HOUR / SET_MIN: time is frozen and tick_1hz is ignored. btn_inc increments the selected field modulo its MAX+1, with no carry into other fields. On the SET_MIN→next transition, sec is cleared to 0.
- SET_AL_HOUR / SET_AL_MIN: btn_inc edits the alarm hour/minute registers, same modulo rule. Time stays frozen. Leaving SET_AL_MIN arms the alarm.
- Simultaneous events:
  - btn_mode+btn_inc in a SET state: mode wins and inc is discarded.
  - btn_mode+tick_1hz in RUN: tick is applied and the state moves to SET_HOUR in the same edge.
- Counter values never exceed MAX; no out-of-range recovery is required.

## Timing
- All outputs are registered. An input sampled at edge t is visible on the outputs after edge t.
- Tick latency is 1 cycle. Example: 23:59:59 plus tick at t reads 00:00:00 after t.
- alarm_hit: asserted for exactly one cycle, in the cycle after the tick that makes the time equal alarm hh:mm:00 while armed and in RUN. It never fires during SET states. It re-fires once per day.
- Buttons and tick are assumed to be single-cycle pulses. A held level counts once per asserted cycle.

## Configuration
- Macro ALARM_EN.
  - Defined: alarm registers, the armed flag, states 3–4 and the comparator are compiled in.
  - Undefined: FSM is RUN→SET_HOUR→SET_MIN→RUN, alarm_hit is tied to 0, and no alarm registers exist.

## Structure
- Shared package clock_pkg holds:
  - state encoding constants: ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_SET_AL_HOUR, ST_SET_AL_MIN
  - the 3-bit state width
  - the 6-bit time-field width
- Sub-module mod_counter:
  - ports: clk, rst, en, max, val, carry
  - carry = en && val==max
  - instantiated three times for sec/min/hour
  - alarm registers reuse it without using carry
- The FSM and the en/select muxing live in clock_time_ctrl.

## Test plan
- Reset at 12:34:56 in SET_MIN → next cycle 00:00:00, mode=0, alarm_hit=0.
- RUN, preload 23:59:58, two ticks → 23:59:59 then 00:00:00, carries in the same cycle.
- btn_mode, btn_inc×25 → hour=1 (wraps at 24). btn_mode, btn_inc×3 → min=3. btn_mode → mode=RUN, sec=0. Ticks during set leave the time frozen.
- In SET_HOUR, btn_mode and btn_inc in the same cycle → mode=SET_MIN, hour unchanged.
- ALARM_EN: set alarm 00:02, run from 00:01:59, tick → alarm_hit high for exactly one cycle after the tick, then low. Repeat from SET_HOUR at 00:02:00 → no pulse.
- No ALARM_EN: from SET_MIN, btn_mode → RUN (mode=0). alarm_hit stays 0 throughout.
